// File: rtl/cpu_step_controller.sv
// Step controller for a multicycle CPU. Brings the slow clock and a bouncy step
// button into clk_in, and issues one-cycle cpu_en pulses in free-run or single-step mode.
module cpu_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             step_btn,
  input  logic             run_mode,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PAUSE  = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_e;

  logic s1_q, s2_q, s3_q, tick_q;
  logic b1_q, b2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic db_q, db_d, db_prev_q, step_req_q;
  state_e state_q, state_d;
  logic cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0] count_q;

  // Synchronisers, slow-clock edge detect and debounced-press detect
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      tick_q     <= 1'b0;
      b1_q       <= 1'b0;
      b2_q       <= 1'b0;
      db_cnt_q   <= '0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      step_req_q <= 1'b0;
    end else begin
      s1_q       <= slow_clk;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      tick_q     <= s2_q & ~s3_q;
      b1_q       <= step_btn;
      b2_q       <= b1_q;
      db_cnt_q   <= db_cnt_d;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      step_req_q <= db_q & ~db_prev_q;
    end
  end

  always_comb begin
    db_cnt_d = db_cnt_q;
    db_d     = db_q;
    if (b2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = b2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PAUSE;
      cpu_en_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      if (cpu_en_q) count_q <= count_q + CNT_W'(1);
    end
  end

  // cpu_en looks at the current state, so events racing a mode change are dropped
  always_comb begin
    state_d  = state_q;
    cpu_en_d = ~halt & (((state_q == RUN) & tick_q) | ((state_q == PAUSE) & step_req_q));
    if (halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        PAUSE:   if (run_mode)  state_d = RUN;
        RUN:     if (!run_mode) state_d = PAUSE;
        HALTED:  state_d = HALTED;
        default: state_d = PAUSE;
      endcase
    end
  end

  assign cpu_en     = cpu_en_q;
  assign state_o    = state_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with DEBOUNCE_CYCLES=4, CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_cpu_step_controller;

  logic       clk_in = 1'b0;
  logic       rst_n, slow_clk, step_btn, run_mode, halt;
  logic       cpu_en;
  logic [1:0] state_o;
  logic [3:0] step_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses   = 0;
  int unsigned p0;

  cpu_step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .step_btn(step_btn),
    .run_mode(run_mode), .halt(halt), .cpu_en(cpu_en), .state_o(state_o),
    .step_count(step_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      if (cpu_en) pulses++;
    end
  endtask

  // One full slow_clk period: 10 cycles high, 10 low
  task automatic slow_period();
    slow_clk = 1'b1;
    step(10);
    slow_clk = 1'b0;
    step(10);
  endtask

  task automatic press();
    step_btn = 1'b1;
    step(8);
    step_btn = 1'b0;
    step(8);
  endtask

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; step_btn = 1'b0; run_mode = 1'b0; halt = 1'b0;
    step(3);
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_state", 32'(state_o), 0);
    check("rst_count", 32'(step_count), 0);
    rst_n = 1'b1;
    step(2);

    // Free-run: 5 slow edges, each pulse exactly 4 cycles after the edge
    run_mode = 1'b1;
    step(1);
    check("run_state", 32'(state_o), 1);
    pulses = 0;
    for (int unsigned e = 0; e < 5; e++) begin
      slow_clk = 1'b1;
      step(3);
      check("run_early", 32'(cpu_en), 0);
      step(1);
      check("run_lat4", 32'(cpu_en), 1);
      step(1);
      check("run_width", 32'(cpu_en), 0);
      step(5);
      slow_clk = 1'b0;
      step(10);
    end
    check("run_pulses", pulses, 5);
    check("run_count", 32'(step_count), 5);

    // Tick coincident with PAUSE->RUN is dropped; the next one pulses
    run_mode = 1'b0;
    step(2);
    check("race_pause", 32'(state_o), 0);
    p0 = pulses;
    slow_clk = 1'b1;
    step(3);
    run_mode = 1'b1;
    step(1);
    check("race_state", 32'(state_o), 1);
    check("race_cpu_en", 32'(cpu_en), 0);
    step(6);
    slow_clk = 1'b0;
    step(10);
    check("race_drop", pulses - p0, 0);
    slow_period();
    check("race_next", pulses - p0, 1);
    check("race_count", 32'(step_count), 6);

    // Press during RUN is discarded, not replayed in PAUSE
    p0 = pulses;
    press();
    run_mode = 1'b0;
    step(6);
    check("run_press_drop", pulses - p0, 0);
    check("run_press_state", 32'(state_o), 0);

    // Debounce: bouncy press yields exactly one step
    p0 = pulses;
    step_btn = 1'b1; step(2);
    step_btn = 1'b0; step(2);
    step_btn = 1'b1; step(10);
    step_btn = 1'b0; step(10);
    check("deb_press", pulses - p0, 1);
    check("deb_count", 32'(step_count), 7);
    p0 = pulses;
    step_btn = 1'b1; step(3);
    step_btn = 1'b0; step(10);
    check("deb_glitch", pulses - p0, 0);

    // Async reset mid-RUN with a tick already in the pipeline
    run_mode = 1'b1;
    step(2);
    slow_clk = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    check("amid_cpu_en", 32'(cpu_en), 0);
    check("amid_state", 32'(state_o), 0);
    check("amid_count", 32'(step_count), 0);
    slow_clk = 1'b0;
    step(2);
    p0 = pulses;
    rst_n = 1'b1;
    step(10);
    check("amid_no_pulse", pulses - p0, 0);
    check("amid_state_run", 32'(state_o), 1);

    // Counter wrap with 4-bit step_count
    run_mode = 1'b0;
    step(2);
    for (int unsigned k = 1; k <= 17; k++) begin
      press();
      if (k == 15) check("wrap_15", 32'(step_count), 15);
      if (k == 16) check("wrap_0", 32'(step_count), 0);
      if (k == 17) check("wrap_1", 32'(step_count), 1);
    end

    // Halt coincident with a RUN tick, then everything ignored until reset
    run_mode = 1'b1;
    step(2);
    p0 = pulses;
    slow_clk = 1'b1;
    step(3);
    halt = 1'b1;
    step(1);
    check("halt_cpu_en", 32'(cpu_en), 0);
    check("halt_state", 32'(state_o), 2);
    halt = 1'b0;
    step(6);
    slow_clk = 1'b0;
    step(10);
    slow_period();
    run_mode = 1'b0;
    step(2);
    press();
    check("halt_no_pulse", pulses - p0, 0);
    check("halt_sticky", 32'(state_o), 2);
    check("halt_count", 32'(step_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
